// File: rtl/referee_arb_n_if.sv
// Source/destination FIFO bundle seen by the referee.
// master: the referee (issues pops, pushes and write data).
// slave:  the FIFO side (reports flags, supplies read data).
interface referee_arb_n_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 12
);
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] almost_full;
   logic [DATA_W-1:0] data_in;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] push;
   logic [DATA_W-1:0] data_out;

   modport master (
      input  empty,
      input  almost_full,
      input  data_in,
      output pop,
      output push,
      output data_out
   );

   modport slave (
      output empty,
      output almost_full,
      output data_in,
      input  pop,
      input  push,
      input  data_out
   );
endinterface

// File: rtl/referee_arb_n.sv
// Referee between NUM_CH source FIFOs and NUM_CH destination FIFOs.
// Stage A picks a non-empty source (round-robin or strict priority) and pops it;
// stage B captures the returned word and pushes it to the destination named by
// the word's destination field. New pops stall while any destination is almost full.
module referee_arb_n #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned DEST_LSB = 8,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             prio_mode,
   referee_arb_n_if.master  bus,
   output logic [CNT_W-1:0] fwd_count
);
   localparam int unsigned CW = $clog2(NUM_CH);
   localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

   logic [NUM_CH-1:0] pop_q, pop_d;
   logic [NUM_CH-1:0] push_q, push_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [CNT_W-1:0]  fwd_count_q, fwd_count_d;
   logic              v1_q, v1_d;
   logic [CW-1:0]     ptr_q, ptr_d;

   logic [NUM_CH-1:0] eligible;
   logic              grant_vld;
   logic [CW-1:0]     grant_idx;
   logic [CW-1:0]     cand;
   logic [CW-1:0]     dest;

   // Stage A: choose the next source to pop; a channel popped last cycle is
   // masked because its empty flag has not yet caught up with that pop.
   always_comb begin
      eligible  = ~bus.empty & ~pop_q;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (prio_mode) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!grant_vld && eligible[i]) begin
               grant_vld = 1'b1;
               grant_idx = CW'(i);
            end
         end
      end else begin
         // Circular search starting just after the last grant; the index wraps
         // naturally because NUM_CH is a power of two.
         for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = ptr_q + CW'(i);
            if (!grant_vld && eligible[cand]) begin
               grant_vld = 1'b1;
               grant_idx = cand;
            end
         end
      end
      if (|bus.almost_full) begin
         grant_vld = 1'b0;
      end
      pop_d = grant_vld ? (ONE_HOT0 << grant_idx) : '0;
      ptr_d = grant_vld ? grant_idx : ptr_q;
   end

   // Stage B: capture the word returned one cycle after a pop and route it.
   always_comb begin
      dest       = bus.data_in[DEST_LSB +: CW];
      v1_d       = |pop_q;
      push_d     = '0;
      data_out_d = data_out_q;
      if (v1_q) begin
         push_d     = ONE_HOT0 << dest;
         data_out_d = bus.data_in;
      end
   end

   // Forwarded-word counter, wraps at its width.
   always_comb begin
      fwd_count_d = fwd_count_q;
      if (|push_q) begin
         fwd_count_d = fwd_count_q + CNT_W'(1);
      end
   end

   // State registers; reset discards any in-flight words.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pop_q       <= '0;
         push_q      <= '0;
         data_out_q  <= '0;
         fwd_count_q <= '0;
         v1_q        <= 1'b0;
         ptr_q       <= CW'(NUM_CH - 1);
      end else begin
         pop_q       <= pop_d;
         push_q      <= push_d;
         data_out_q  <= data_out_d;
         fwd_count_q <= fwd_count_d;
         v1_q        <= v1_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.pop      = pop_q;
   assign bus.push     = push_q;
   assign bus.data_out = data_out_q;
   assign fwd_count    = fwd_count_q;
endmodule

// File: tb/tb_referee_arb_n.sv
// Bench for referee_arb_n: source FIFO models feed the DUT, a reference model
// predicts each pop and queues the expected push, a monitor compares.
module tb_referee_arb_n;
   localparam int NUM_CH   = 4;
   localparam int DATA_W   = 12;
   localparam int DEST_LSB = 8;
   localparam int CNT_W    = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             prio_mode;
   logic [CNT_W-1:0] fwd_count;

   referee_arb_n_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

   referee_arb_n #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEST_LSB(DEST_LSB), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .prio_mode(prio_mode), .bus(bus), .fwd_count(fwd_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                due;
      logic [NUM_CH-1:0] push;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t              sb[$];
   logic [DATA_W-1:0] src_q[NUM_CH][$];
   logic [DATA_W-1:0] ref_q[NUM_CH][$];
   int                checks = 0;
   int                errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration rule: lowest eligible index, or first eligible
   // after the last grant going round the ring.
   function automatic int pick(input logic [NUM_CH-1:0] elig, input int ptr, input bit prio);
      if (prio) begin
         for (int c = 0; c < NUM_CH; c++) if (elig[c]) return c;
      end else begin
         for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (ptr + k) % NUM_CH;
            if (elig[c]) return c;
         end
      end
      return -1;
   endfunction

   task automatic add_word(input int c, input int dest);
      logic [DATA_W-1:0] w;
      w = DATA_W'($urandom);
      w[DEST_LSB +: 2] = 2'(dest);
      src_q[c].push_back(w);
      ref_q[c].push_back(w);
      bus.empty[c] = 1'b0;
   endtask

   task automatic add_fixed(input int c, input logic [DATA_W-1:0] w);
      src_q[c].push_back(w);
      ref_q[c].push_back(w);
      bus.empty[c] = 1'b0;
   endtask

   // One clock of the source-FIFO side: a pop seen during a cycle returns its
   // word in the next cycle, and the empty flag updates one cycle late.
   task automatic step(input logic rst, input logic pm, input logic [NUM_CH-1:0] af);
      logic [NUM_CH-1:0] p;
      @(negedge clk);
      p = bus.pop;
      @(posedge clk);
      #1;
      bus.data_in = DATA_W'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
         if (p[c] === 1'b1) begin
            chk("src_underflow", 32'(src_q[c].size() > 0), 32'd1);
            if (src_q[c].size() > 0) bus.data_in = src_q[c].pop_front();
         end
      end
      for (int c = 0; c < NUM_CH; c++) bus.empty[c] = (src_q[c].size() == 0);
      reset            = rst;
      prio_mode        = pm;
      bus.almost_full  = af;
   endtask

   // Monitor and reference model.
   initial begin
      int                n;
      int                m_ptr;
      int                m_cnt;
      int                g;
      logic [NUM_CH-1:0] m_pop;
      logic [NUM_CH-1:0] elig;
      logic [DATA_W-1:0] m_dout;
      logic [DATA_W-1:0] w;
      int                pushed;
      exp_t              e;
      n      = 0;
      m_ptr  = NUM_CH - 1;
      m_cnt  = 0;
      m_pop  = '0;
      m_dout = '0;
      repeat (2) @(posedge clk);
      forever begin
         @(negedge clk);
         n++;
         chk("pop", 32'(bus.pop), 32'(m_pop));
         chk("fwd_count", 32'(fwd_count), 32'(m_cnt));
         if (sb.size() > 0 && sb[0].due == n) begin
            e = sb.pop_front();
            chk("push", 32'(bus.push), 32'(e.push));
            chk("data_out", 32'(bus.data_out), 32'(e.data));
            m_dout = e.data;
            pushed = 1;
         end else begin
            chk("push_idle", 32'(bus.push), 32'd0);
            chk("data_out_hold", 32'(bus.data_out), 32'(m_dout));
            pushed = 0;
         end
         if (reset === 1'b0) begin
            m_pop  = '0;
            m_ptr  = NUM_CH - 1;
            m_cnt  = 0;
            m_dout = '0;
            sb.delete();
         end else begin
            m_cnt = (m_cnt + pushed) % (1 << CNT_W);
            elig  = ~bus.empty & ~m_pop;
            g     = (|bus.almost_full) ? -1 : pick(elig, m_ptr, prio_mode);
            if (g >= 0) begin
               m_ptr = g;
               m_pop = NUM_CH'(1) << g;
               if (ref_q[g].size() > 0) begin
                  w      = ref_q[g].pop_front();
                  e.due  = n + 3;
                  e.push = NUM_CH'(1) << w[DEST_LSB +: 2];
                  e.data = w;
                  sb.push_back(e);
               end
            end else begin
               m_pop = '0;
            end
         end
      end
   end

   // Stimulus.
   initial begin
      logic              pm;
      logic [NUM_CH-1:0] af;
      logic              rst;
      reset           = 1'b0;
      prio_mode       = 1'b0;
      bus.almost_full = '0;
      bus.data_in     = '0;
      bus.empty       = '1;

      // Round-robin with all sources loaded; ch2 leads with 0x1A5 (dest 1).
      add_fixed(2, 12'h1A5);
      for (int c = 0; c < NUM_CH; c++) for (int k = 0; k < 5; k++) add_word(c, $urandom_range(0, 3));
      repeat (3) step(1'b0, 1'b0, '0);
      repeat (40) step(1'b1, 1'b0, '0);

      // Single source with three words.
      for (int k = 0; k < 3; k++) add_word(3, k);
      repeat (12) step(1'b1, 1'b0, '0);

      // Strict priority between ch0 and ch2.
      for (int k = 0; k < 4; k++) add_word(0, $urandom_range(0, 3));
      for (int k = 0; k < 6; k++) add_word(2, $urandom_range(0, 3));
      repeat (25) step(1'b1, 1'b1, '0);

      // Backpressure pulse on destination 1 while traffic flows.
      for (int c = 0; c < NUM_CH; c++) for (int k = 0; k < 4; k++) add_word(c, $urandom_range(0, 3));
      repeat (3) step(1'b1, 1'b0, '0);
      repeat (4) step(1'b1, 1'b0, 4'b0010);
      repeat (30) step(1'b1, 1'b0, '0);

      // Reset while words are in flight.
      for (int c = 0; c < NUM_CH; c++) for (int k = 0; k < 3; k++) add_word(c, $urandom_range(0, 3));
      repeat (4) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      repeat (30) step(1'b1, 1'b0, '0);

      // Random traffic, backpressure, mode switches and occasional reset.
      pm = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            int c;
            c = $urandom_range(0, NUM_CH - 1);
            if (src_q[c].size() < 8) add_word(c, $urandom_range(0, 3));
         end
         af  = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
         if ($urandom_range(0, 99) == 0) pm = ~pm;
         rst = ($urandom_range(0, 499) != 0);
         step(rst, pm, af);
      end

      // Drain everything that is left.
      repeat (100) step(1'b1, pm, '0);
      @(negedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) chk("src_drained", 32'(src_q[c].size()), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
